// File: rtl/memory_stage.sv
// Purpose: MEM pipeline stage with EX/MEM and MEM/WB registers, a word-addressed data memory and a sticky misalignment flag.
// Latency: pc_src/branch_target 1 edge after the execute inputs; wb_* outputs 2 edges after them.
// Backpressure: stall freezes both pipeline registers and the memory; flush only turns the incoming instruction into a bubble.
module memory_stage #(
    parameter int ADDR_BITS  = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  branch,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic [6:0]            branch_pc,
    input  logic                  zero,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] data2_out,
    input  logic [4:0]            dst,
    output logic                  pc_src,
    output logic [6:0]            branch_target,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [DATA_WIDTH-1:0] wb_read_data,
    output logic [DATA_WIDTH-1:0] wb_alu_result,
    output logic [4:0]            wb_dst,
    output logic                  mem_fault
);

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [6:0]            branch_pc;
        logic                  zero;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [4:0]            dst;
    } ex_mem_t;

    ex_mem_t ex_in;
    ex_mem_t ex_mem;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    logic [ADDR_BITS-1:0]  word_addr;
    logic                  misaligned;
    logic                  load_fault;
    logic                  store_en;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        ex_in            = '0;
        ex_in.mem_read   = mem_read;
        ex_in.mem_write  = mem_write;
        ex_in.branch     = branch;
        ex_in.reg_write  = reg_write;
        ex_in.mem_to_reg = mem_to_reg;
        ex_in.branch_pc  = branch_pc;
        ex_in.zero       = zero;
        ex_in.alu_result = alu_result;
        ex_in.store_data = data2_out;
        ex_in.dst        = dst;
    end

    // Higher address bits are dropped on purpose so the memory wraps.
    assign word_addr  = ex_mem.alu_result[ADDR_BITS+1:2];
    assign misaligned = (ex_mem.mem_read || ex_mem.mem_write) && (ex_mem.alu_result[1:0] != 2'b00);
    assign load_fault = ex_mem.mem_read && misaligned;
    assign store_en   = ex_mem.mem_write && !misaligned && !stall && !reset;
    assign rd_data    = mem[word_addr];

    assign pc_src        = ex_mem.branch && ex_mem.zero;
    assign branch_target = ex_mem.branch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem <= '0;
        end else if (flush) begin
            ex_mem            <= ex_in;
            ex_mem.mem_read   <= 1'b0;
            ex_mem.mem_write  <= 1'b0;
            ex_mem.branch     <= 1'b0;
            ex_mem.reg_write  <= 1'b0;
            ex_mem.mem_to_reg <= 1'b0;
        end else if (!stall) begin
            ex_mem <= ex_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_dst        <= '0;
        end else if (!stall) begin
            wb_reg_write  <= ex_mem.reg_write && !load_fault;
            wb_mem_to_reg <= ex_mem.mem_to_reg;
            wb_read_data  <= load_fault ? '0 : rd_data;
            wb_alu_result <= ex_mem.alu_result;
            wb_dst        <= ex_mem.dst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_fault <= 1'b0;
        end else if (misaligned) begin
            mem_fault <= 1'b1;
        end
    end

    // No reset on the array; the read above sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[word_addr] <= ex_mem.store_data;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a transaction-level model is checked every cycle,
// plus literal expectations at the points of interest.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        mem_read, mem_write, branch, reg_write, mem_to_reg;
    logic [6:0]  branch_pc;
    logic        zero;
    logic [31:0] alu_result, data2_out;
    logic [4:0]  dst;
    logic        pc_src;
    logic [6:0]  branch_target;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_dst;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_BITS(7), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .branch_pc(branch_pc), .zero(zero), .alu_result(alu_result),
        .data2_out(data2_out), .dst(dst),
        .pc_src(pc_src), .branch_target(branch_target),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
        .wb_dst(wb_dst), .mem_fault(mem_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        rd, wr, br, rw, m2r, z;
        logic [6:0]  bpc;
        logic [31:0] alu, d2;
        logic [4:0]  dst;
    } ins_t;

    ins_t        m_ex;
    logic        m_wb_rw, m_wb_m2r, m_fault, model_live = 1'b0;
    logic [31:0] m_wb_rd, m_wb_alu;
    logic [4:0]  m_wb_dst;
    logic [31:0] m_mem [128];

    initial for (int i = 0; i < 128; i++) m_mem[i] = 'x;

    always @(posedge clk) begin
        ins_t cur;
        int   w;
        bit   bad, ldbad;
        cur = '{rd: mem_read, wr: mem_write, br: branch, rw: reg_write, m2r: mem_to_reg,
                z: zero, bpc: branch_pc, alu: alu_result, d2: data2_out, dst: dst};
        if (reset) begin
            m_ex = '{rd: 0, wr: 0, br: 0, rw: 0, m2r: 0, z: 0, bpc: 0, alu: 0, d2: 0, dst: 0};
            m_wb_rw = 0; m_wb_m2r = 0; m_wb_rd = 0; m_wb_alu = 0; m_wb_dst = 0;
            m_fault = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            w     = int'((m_ex.alu / 4) % 128);
            bad   = (m_ex.rd || m_ex.wr) && (m_ex.alu % 4 != 0);
            ldbad = bad && m_ex.rd;
            if (bad) m_fault = 1;
            if (!stall) begin
                m_wb_rw  = m_ex.rw && !ldbad;
                m_wb_m2r = m_ex.m2r;
                m_wb_rd  = ldbad ? 32'h0 : m_mem[w];
                m_wb_alu = m_ex.alu;
                m_wb_dst = m_ex.dst;
                if (m_ex.wr && !bad) m_mem[w] = m_ex.d2;
            end
            if (flush) begin
                cur.rd = 0; cur.wr = 0; cur.br = 0; cur.rw = 0; cur.m2r = 0;
                m_ex = cur;
            end else if (!stall) begin
                m_ex = cur;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("pc_src",        32'(pc_src),        32'(m_ex.br && m_ex.z));
            chk("branch_target", 32'(branch_target), 32'(m_ex.bpc));
            chk("wb_reg_write",  32'(wb_reg_write),  32'(m_wb_rw));
            chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m_wb_m2r));
            chk("wb_alu_result", wb_alu_result,      m_wb_alu);
            chk("wb_dst",        32'(wb_dst),        32'(m_wb_dst));
            chk("mem_fault",     32'(mem_fault),     32'(m_fault));
            if (!$isunknown(m_wb_rd)) chk("wb_read_data", wb_read_data, m_wb_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, st, fl, rd, wr, br, z, rw, m2r,
                         input logic [6:0] bpc, input logic [31:0] alu, d2, input logic [4:0] d);
        reset = r; stall = st; flush = fl;
        mem_read = rd; mem_write = wr; branch = br; zero = z;
        reg_write = rw; mem_to_reg = m2r; branch_pc = bpc;
        alu_result = alu; data2_out = d2; dst = d;
        @(posedge clk);
        #2;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 32'h0, 32'h0, 5'd0);
    endtask
    task automatic st(input logic [31:0] a, input logic [31:0] v);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 7'd0, a, v, 5'd0);
    endtask
    task automatic ld(input logic [31:0] a, input logic [4:0] d);
        drive(0, 0, 0, 1, 0, 0, 0, 1, 1, 7'd0, a, 32'h0, d);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 32'h0, 32'h0, 5'd0);
        drive(1, 1, 1, 0, 1, 1, 1, 1, 1, 7'd3, 32'h8, 32'h1, 5'd1);
        chk("reset pc_src", 32'(pc_src), 32'h0);
        chk("reset branch_target", 32'(branch_target), 32'h0);
        chk("reset wb_read_data", wb_read_data, 32'h0);
        chk("reset wb_reg_write", 32'(wb_reg_write), 32'h0);
        chk("reset mem_fault", 32'(mem_fault), 32'h0);

        // store then load back
        st(32'h10, 32'hDEADBEEF);
        ld(32'h10, 5'd3);
        nop();
        chk("load data", wb_read_data, 32'hDEADBEEF);
        chk("load m2r", 32'(wb_mem_to_reg), 32'h1);
        chk("load dst", 32'(wb_dst), 32'h3);

        // read-before-write with read and write to the same word
        st(32'h20, 32'h11111111);
        drive(0, 0, 0, 1, 1, 0, 0, 1, 1, 7'd0, 32'h20, 32'h22222222, 5'd4);
        nop();
        chk("rbw old data", wb_read_data, 32'h11111111);
        ld(32'h20, 5'd4);
        nop();
        chk("rbw new data", wb_read_data, 32'h22222222);

        // branch taken / not taken
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 7'd5, 32'h0, 32'h0, 5'd0);
        chk("branch taken", 32'(pc_src), 32'h1);
        chk("branch target", 32'(branch_target), 32'h5);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 7'd9, 32'h0, 32'h0, 5'd0);
        chk("branch not taken", 32'(pc_src), 32'h0);

        // flush suppresses store, branch and writeback
        st(32'h30, 32'h0000AAAA);
        drive(0, 0, 1, 0, 1, 1, 1, 1, 0, 7'd6, 32'h30, 32'h00000BAD, 5'd7);
        chk("flush pc_src", 32'(pc_src), 32'h0);
        nop();
        chk("flush wb_reg_write", 32'(wb_reg_write), 32'h0);
        st(32'h48, 32'h00007777);
        st(32'h40, 32'h00000001);
        ld(32'h30, 5'd8);

        // stall during a pending store
        st(32'h40, 32'h00005555);
        chk("pre-stall data", wb_read_data, 32'h0000AAAA);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 7'd0, 32'h48, 32'h00009999, 5'd9);
            chk("stall wb_alu_result", wb_alu_result, 32'h30);
            chk("stall wb_read_data", wb_read_data, 32'h0000AAAA);
        end
        nop();
        chk("post-stall wb_alu_result", wb_alu_result, 32'h40);
        ld(32'h40, 5'd10);
        ld(32'h48, 5'd11);
        chk("stall store data", wb_read_data, 32'h00005555);
        nop();
        chk("stalled input dropped", wb_read_data, 32'h00007777);

        // misaligned load, wrapped store, misaligned store
        ld(32'h13, 5'd12);
        nop();
        chk("misaligned fault", 32'(mem_fault), 32'h1);
        chk("misaligned data", wb_read_data, 32'h0);
        chk("misaligned reg_write", 32'(wb_reg_write), 32'h0);
        st(32'h204, 32'h0000CAFE);
        ld(32'h004, 5'd13);
        nop();
        chk("wrap data", wb_read_data, 32'h0000CAFE);
        st(32'h42, 32'h0000BEEF);
        ld(32'h40, 5'd14);
        nop();
        chk("misaligned store ignored", wb_read_data, 32'h00005555);

        // reset during a pending store
        st(32'h40, 32'h00006666);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 32'h0, 32'h0, 5'd0);
        chk("reset2 fault", 32'(mem_fault), 32'h0);
        chk("reset2 wb_alu_result", wb_alu_result, 32'h0);
        chk("reset2 wb_dst", 32'(wb_dst), 32'h0);
        chk("reset2 pc_src", 32'(pc_src), 32'h0);
        ld(32'h40, 5'd15);
        nop();
        chk("reset suppressed store", wb_read_data, 32'h00005555);
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
